spi_master_byte: RTL
====================

Name: spi_master_byte

Overview:
- FPGA-side SPI initiator. Drives sck, nss and sdo, and samples sdi, to exchange one byte per transaction with an external SPI responder (MCU or peripheral).
- Complement of the team's spi_byte responder: same mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Used for FPGA-originated telemetry (e.g. motor status) and for reading SPI sensors.
- Simple start/busy/done handshake toward user logic. Optional nss hold allows multi-byte frames.

Parameters:
- HALF_PERIOD, 4, system clocks per sck half-period; legal range >= 2. Counter width = $clog2(HALF_PERIOD).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a byte transfer; accepted only when busy=0.
- tx_byte  in  8  byte to send; captured on the accepting edge.
- hold_nss  in  1  captured with start; 1 keeps nss low after this byte.
- abort  in  1  synchronous; cancels the current transfer.
- busy  out  1  high from the accepting edge until the block is ready for a new start.
- done  out  1  one-cycle pulse when rx_byte is valid.
- rx_byte  out  8  byte received on sdi; holds its value until the next done.
- sck  out  1  SPI clock; idles 0.
- sdo  out  1  MOSI.
- sdi  in  1  MISO.
- nss  out  1  active-low chip select; idles 1.

Behaviour:
- Reset (async, immediate): nss=1, sck=0, sdo=0, busy=0, done=0, rx_byte=8'h00, state=IDLE, held=0.
- States: IDLE, HELD, LEAD, SCK_HI, SCK_LO, TRAIL, GAP. A half counter counts 0..HALF_PERIOD-1 in every timed state.
- IDLE: nss=1, sck=0.
  - start=1: load shift register with tx_byte, latch hold_nss, nss<=0, sdo<=tx_byte[7], busy<=1, bit count<=0, go to LEAD.
- HELD: nss=0, sck=0, busy=0.
  - start=1: same load as IDLE, go to LEAD.
  - abort=1: go to GAP.
- LEAD: sck=0 for HALF_PERIOD clocks (responder setup time), then sck<=1, go to SCK_HI.
- SCK_HI: sck=1 for HALF_PERIOD clocks. On the final clock of the phase, in one edge:
  - shift sdi into rx shift LSB;
  - sck<=0;
  - if bit count==7 go to TRAIL, else go to SCK_LO.
- SCK_LO: on entry sdo<=next bit and bit count increments. Hold sck=0 for HALF_PERIOD clocks, then sck<=1, go to SCK_HI.
- TRAIL: sck=0 for HALF_PERIOD clocks. On exit, in one edge:
  - rx_byte<=rx shift, done<=1 for one cycle;
  - latched hold_nss=1: go to HELD, nss stays 0, busy<=0;
  - otherwise: nss<=1, go to GAP.
- GAP: nss=1 for HALF_PERIOD clocks (minimum deselect time), then busy<=0, go to IDLE.
- Latency:
  - done asserts exactly 17*HALF_PERIOD clocks after the accepting edge (68 at default).
  - Exactly 8 sck rising edges per byte; sck high time and low time are each HALF_PERIOD clocks.
- sdo changes only while sck=0 and never within HALF_PERIOD clocks before a sck rise.
- start while busy=1 is ignored; no queueing.
- abort in LEAD, SCK_HI, SCK_LO or TRAIL:
  - sck<=0, nss<=1, no done, rx_byte unchanged, go to GAP.
  - abort takes priority over a phase transition on the same edge.
- abort in IDLE has no effect.
- abort and start on the same edge in IDLE: start wins.
- sdo returns to 0 in IDLE and GAP, and holds its last bit in HELD.
- Reset asserted mid-transfer: outputs reach reset values immediately; no done pulse.

Test Plan:
- HALF_PERIOD=4; start with tx_byte=8'hA5, hold_nss=0; responder model returns 8'h3C -> sdo bits 1,0,1,0,0,1,0,1 sampled at 8 sck rises; done at +68 clocks; rx_byte=8'h3C; nss high for 4 clocks, then busy=0.
- Two bytes: 8'h01 with hold_nss=1, then 8'h80 with hold_nss=0, started the cycle after the first done -> nss stays low through both bytes; 16 sck rises total; two done pulses; each rx_byte matches the model.
- start pulsed at +10 and +40 during a transfer -> ignored; exactly 8 sck rises; one done.
- abort at +30 clocks -> sck=0 and nss=1 on the next edge; no done; rx_byte keeps its prior value; busy drops 4 clocks later.
- rst asserted mid-SCK_HI -> sck=0, nss=1, busy=0, rx_byte=8'h00 without waiting for a clock edge. A new start after release completes normally.
- HALF_PERIOD=2, tx_byte=8'hFF, sdi tied 0 -> done at +34 clocks; rx_byte=8'h00; sck period 4 clocks.

Source files
------------

// File: rtl/spi_master_byte_if.sv
// User-side handshake for spi_master_byte: start/busy/done plus the data bytes.
// "master" is the requesting user logic, "slave" is the SPI engine serving it.
interface spi_master_byte_if;
  logic       start;
  logic [7:0] tx_byte;
  logic       hold_nss;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;

  modport master (
    output start, tx_byte, hold_nss, abort,
    input  busy, done, rx_byte
  );

  modport slave (
    input  start, tx_byte, hold_nss, abort,
    output busy, done, rx_byte
  );
endinterface

// File: rtl/spi_master_byte.sv
// Mode-0, MSB-first, single-byte SPI initiator with optional nss hold for multi-byte frames.
// Every timed phase lasts HALF_PERIOD clocks; all outputs are registered.
module spi_master_byte #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_byte_if.slave ctl,
  output logic             sck,
  output logic             sdo,
  input  logic             sdi,
  output logic             nss
);
  localparam int unsigned CNT_W = $clog2(HALF_PERIOD);

  typedef enum logic [2:0] {IDLE, HELD, LEAD, SCK_HI, SCK_LO, TRAIL, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             held_q, held_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sck_d, sdo_d, nss_d;
  logic             last, load, kill;

  assign last        = (cnt_q == CNT_W'(HALF_PERIOD - 1));
  assign ctl.busy    = busy_q;
  assign ctl.done    = done_q;
  assign ctl.rx_byte = rx_byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_byte_q <= '0;
      held_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck       <= 1'b0;
      sdo       <= 1'b0;
      nss       <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
      held_q    <= held_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sck       <= sck_d;
      sdo       <= sdo_d;
      nss       <= nss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = last ? '0 : cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    held_d    = held_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sck_d     = sck;
    sdo_d     = sdo;
    nss_d     = nss;
    load      = 1'b0;
    kill      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sck_d = 1'b0;
        nss_d = 1'b1;
        sdo_d = 1'b0;
        load  = ctl.start;
      end
      HELD: begin
        cnt_d = '0;
        sck_d = 1'b0;
        if (ctl.start) begin
          load = 1'b1;
        end else if (ctl.abort) begin
          state_d = GAP;
          nss_d   = 1'b1;
          sdo_d   = 1'b0;
          busy_d  = 1'b1;
          held_d  = 1'b0;
        end
      end
      LEAD, SCK_LO: begin
        if (ctl.abort) begin
          kill = 1'b1;
        end else if (last) begin
          sck_d   = 1'b1;
          state_d = SCK_HI;
        end
      end
      SCK_HI: begin
        if (ctl.abort) begin
          kill = 1'b1;
        end else if (last) begin
          rx_sh_d = {rx_sh_q[6:0], sdi};
          sck_d   = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = TRAIL;
          end else begin
            // next bit goes out on the falling edge, a full half-period ahead of the rise
            state_d = SCK_LO;
            sdo_d   = tx_q[6];
            tx_d    = {tx_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      TRAIL: begin
        if (ctl.abort) begin
          kill = 1'b1;
        end else if (last) begin
          rx_byte_d = rx_sh_q;
          done_d    = 1'b1;
          if (held_q) begin
            state_d = HELD;
            busy_d  = 1'b0;
          end else begin
            nss_d   = 1'b1;
            sdo_d   = 1'b0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        nss_d = 1'b1;
        sdo_d = 1'b0;
        if (last) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tx_d    = ctl.tx_byte;
      held_d  = ctl.hold_nss;
      nss_d   = 1'b0;
      sdo_d   = ctl.tx_byte[7];
      busy_d  = 1'b1;
      bit_d   = '0;
      cnt_d   = '0;
      state_d = LEAD;
    end

    if (kill) begin
      sck_d   = 1'b0;
      nss_d   = 1'b1;
      sdo_d   = 1'b0;
      held_d  = 1'b0;
      cnt_d   = '0;
      state_d = GAP;
    end
  end
endmodule
